// File: rtl/reg_tag_file.sv
// Architectural register file with per-register rename tags, used by an
// out-of-order core. Each register holds a value, a busy bit and the
// reorder-buffer tag of the pending producer. Reads are combinational with
// a commit bypass. busy_cnt tracks how many registers are currently busy.
module reg_tag_file #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned NRD   = 2,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  ren_en,
  input  logic [AW-1:0]         ren_addr,
  input  logic [TAG_W-1:0]      ren_tag,
  input  logic                  cmt_en,
  input  logic [AW-1:0]         cmt_addr,
  input  logic [TAG_W-1:0]      cmt_tag,
  input  logic [XLEN-1:0]       cmt_data,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  output logic [NRD*TAG_W-1:0]  rd_tag,
  output logic [AW:0]           busy_cnt
);

  logic [XLEN-1:0]  r_value [NREG];
  logic [TAG_W-1:0] r_tag   [NREG];
  logic [NREG-1:0]  r_busy;
  logic [AW:0]      r_busy_cnt;

  logic             w_ren_ok;
  logic             w_cmt_ok;
  logic             w_cmt_hit;
  logic             w_inc;
  logic             w_dec;
  logic [AW:0]      w_busy_cnt_d;

  // Qualify requests and derive the incremental busy-count update
  always_comb begin
    w_ren_ok  = ren_en && (ren_addr != '0) && !flush_in;
    w_cmt_ok  = cmt_en && (cmt_addr != '0);
    w_cmt_hit = w_cmt_ok && r_busy[cmt_addr] && (r_tag[cmt_addr] == cmt_tag);
    w_inc     = w_ren_ok && !r_busy[ren_addr];
    // A matched commit overtaken by a same-address rename leaves the reg busy
    w_dec     = w_cmt_hit && !(w_ren_ok && (ren_addr == cmt_addr));
    w_busy_cnt_d = r_busy_cnt;
    if (flush_in) begin
      w_busy_cnt_d = '0;
    end else if (w_inc && !w_dec) begin
      w_busy_cnt_d = r_busy_cnt + (AW+1)'(1);
    end else if (w_dec && !w_inc) begin
      w_busy_cnt_d = r_busy_cnt - (AW+1)'(1);
    end
  end

  // Register state: value write on commit, then flush or commit-clear/rename
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
      end
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else if (rdy_in) begin
      if (w_cmt_ok) begin
        r_value[cmt_addr] <= cmt_data;
      end
      if (flush_in) begin
        for (int i = 0; i < int'(NREG); i++) begin
          r_tag[i] <= '0;
        end
        r_busy <= '0;
      end else begin
        if (w_cmt_hit) begin
          r_busy[cmt_addr] <= 1'b0;
          r_tag[cmt_addr]  <= '0;
        end
        // Later assignment lets a same-address rename win over the commit
        if (w_ren_ok) begin
          r_busy[ren_addr] <= 1'b1;
          r_tag[ren_addr]  <= ren_tag;
        end
      end
      r_busy_cnt <= w_busy_cnt_d;
    end
  end

  // Combinational read ports with commit bypass; x0 is hardwired to zero
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_tag  = '0;
    for (int k = 0; k < int'(NRD); k++) begin
      logic [AW-1:0] a;
      a = rd_addr[k*AW +: AW];
      if (a != '0) begin
        if (r_busy[a] && cmt_en && (cmt_addr == a) && (cmt_tag == r_tag[a])) begin
          rd_data[k*XLEN +: XLEN] = cmt_data;
        end else begin
          rd_data[k*XLEN +: XLEN] = r_value[a];
          rd_busy[k]              = r_busy[a];
          rd_tag[k*TAG_W +: TAG_W] = r_busy[a] ? r_tag[a] : '0;
        end
      end
    end
  end

  assign busy_cnt = r_busy_cnt;

endmodule

// File: doc/reg_tag_file.md
REG_TAG_FILE -- requirements
Module: reg_tag_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter NREG, default 32, architectural register count, power of two; AW = log2(NREG).
REQ-003 SHALL have parameter TAG_W, default 4, reorder-buffer tag width.
REQ-004 SHALL have parameter NRD, default 2, read-port count.
REQ-005 SHALL have port clk_in  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst_in  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rdy_in  in  1  global enable; 0 freezes all state.
REQ-008 SHALL have port flush_in  in  1  mispredict flush, drops all renames.
REQ-009 SHALL have port ren_en  in  1  rename request.
REQ-010 SHALL have port ren_addr  in  AW  destination register being renamed.
REQ-011 SHALL have port ren_tag  in  TAG_W  tag of producing entry.
REQ-012 SHALL have port cmt_en  in  1  commit request.
REQ-013 SHALL have port cmt_addr  in  AW  committed destination register.
REQ-014 SHALL have port cmt_tag  in  TAG_W  tag of committing entry.
REQ-015 SHALL have port cmt_data  in  XLEN  committed value.
REQ-016 SHALL have port rd_addr  in  NRD*AW  packed read addresses, port k at bits [k*AW +: AW].
REQ-017 SHALL have port rd_data  out  NRD*XLEN  packed read values.
REQ-018 SHALL have port rd_busy  out  NRD  1 = value pending, use rd_tag.
REQ-019 SHALL have port rd_tag  out  NRD*TAG_W  packed pending tags.
REQ-020 SHALL have port busy_cnt  out  AW+1  number of registers currently busy.

Function
REQ-021 SHALL hold per register: value[XLEN], busy bit, tag[TAG_W].
REQ-022 Register 0 SHALL always read value 0, busy 0, tag 0; rename and commit to address 0 ignored.
REQ-023 Read ports SHALL be combinational, independent, zero latency.
REQ-024 Read port k, address a != 0: if busy[a] and cmt_en and cmt_addr==a and cmt_tag==tag[a] -> data=cmt_data, busy=0, tag=0 (commit bypass).
REQ-025 Otherwise read SHALL return value[a], busy[a], and tag[a] when busy else 0.
REQ-026 Same-cycle rename SHALL NOT affect reads (sources read before destination renamed).
REQ-027 Bypass SHALL apply regardless of rdy_in and flush_in.
REQ-028 All updates SHALL occur on rising clk_in only when rdy_in=1; rdy_in=0 holds every register, ignores ren/cmt/flush.
REQ-029 Commit (cmt_en, addr != 0) SHALL write value[cmt_addr]=cmt_data unconditionally.
REQ-030 Commit SHALL clear busy[cmt_addr] only if busy set and tag[cmt_addr]==cmt_tag; mismatched tag leaves busy/tag unchanged (newer rename outstanding).
REQ-031 Rename (ren_en, addr != 0, no flush) SHALL set busy[ren_addr]=1, tag[ren_addr]=ren_tag, overwriting any prior rename.
REQ-032 Rename and commit to same address same cycle: value written, rename wins (busy=1, tag=ren_tag).
REQ-033 flush_in=1 SHALL clear every busy bit and tag, ignore ren_en, still perform the commit value write.
REQ-034 busy_cnt SHALL equal population count of busy bits after each edge, maintained incrementally (+1 rename of idle reg, -1 tag-matched commit, net 0 when both on same address or rename of already-busy reg); flush sets 0.
REQ-035 busy_cnt SHALL be registered, range 0..NREG-1, never wraps.

Reset
REQ-036 rst_in=0 SHALL immediately, without clock, clear all values, busy bits, tags, busy_cnt to 0.
REQ-037 While rst_in=0, rd_data, rd_busy, rd_tag SHALL read 0 on every port.
REQ-038 Deassertion SHALL take effect at the next rising clk_in; no request is lost if presented after release.

Verification
REQ-039 Reset, then read x5 on both ports -> data 0, busy 0, busy_cnt 0; assert rst_in=0 mid-run with busy regs -> outputs 0 before next edge.
REQ-040 Rename x3 tag 7; next cycle read x3 -> busy 1, tag 7, busy_cnt 1; commit x3 tag 7 data 0xDEADBEEF same cycle as read -> data 0xDEADBEEF busy 0 combinationally; after edge busy_cnt 0.
REQ-041 Rename x4 tag 2, rename x4 tag 9, commit x4 tag 2 data 0x11 -> value 0x11 stored, busy 1, tag 9, busy_cnt 1.
REQ-042 Same cycle rename x6 tag 5 and commit x6 (matching old tag 1) data 0x22 -> after edge busy 1 tag 5 value 0x22; same-cycle read of x6 showed 0x22 busy 0.
REQ-043 Rename x1,x2,x7 then flush with commit x2 data 0x33 -> all busy 0, busy_cnt 0, x2 reads 0x33; ren_en during flush ignored.
REQ-044 rdy_in=0 with rename/commit/flush asserted -> no state or busy_cnt change; rename/commit to x0 -> x0 reads 0, busy_cnt unchanged.
